// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the execute-stage controller and muldiv_unit.
interface muldiv_unit_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDOp;
    logic        Start;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output A, B, MDOp, Start, input Busy, Done, HI, LO);
    modport slave  (input A, B, MDOp, Start, output Busy, Done, HI, LO);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit owning the MIPS HI/LO pair.
// Multiply is right-shifting shift-add; divide is restoring shift-subtract.
// Both share one 64-bit working register: {upper accumulator, lower operand}.
module muldiv_unit (
    input  logic          clk,
    input  logic          rstn,
    muldiv_unit_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] p_q, p_d;      // working register / product / {rem, quo}
    logic [31:0] mc_q, mc_d;    // multiplicand or divisor magnitude
    logic [31:0] a_q, a_d;      // raw dividend, returned in HI on divide-by-zero
    logic        div_q, div_d;
    logic        neg_q, neg_d;  // product / quotient sign
    logic        aneg_q, aneg_d; // remainder sign follows dividend
    logic        bzero_q, bzero_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        sgn;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_rs;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] prod_neg;

    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

    // Operand conditioning and one iteration of each algorithm.
    always_comb begin
        sgn     = (bus.MDOp == OP_MULT) || (bus.MDOp == OP_DIV);
        a_mag   = (sgn && bus.A[31]) ? -bus.A : bus.A;
        b_mag   = (sgn && bus.B[31]) ? -bus.B : bus.B;
        mul_sum = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, mc_q} : 33'd0);
        div_rs  = {p_q[63:32], p_q[31]};
        div_ge  = div_rs >= {1'b0, mc_q};
        // Remainder stays below 2^32 after a successful subtract, so the
        // low 32 bits of the difference are exact.
        div_rem = div_ge ? (div_rs[31:0] - mc_q) : div_rs[31:0];
        prod_neg = -p_q;
    end

    // Next-state logic for the IDLE -> RUN x32 -> FINISH sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        mc_d    = mc_q;
        a_d     = a_q;
        div_d   = div_q;
        neg_d   = neg_q;
        aneg_d  = aneg_q;
        bzero_d = bzero_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    case (bus.MDOp)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d = S_RUN;
                            busy_d  = 1'b1;
                            cnt_d   = 5'd0;
                            div_d   = (bus.MDOp == OP_DIV) || (bus.MDOp == OP_DIVU);
                            neg_d   = sgn && (bus.A[31] ^ bus.B[31]);
                            aneg_d  = sgn && bus.A[31];
                            bzero_d = (bus.B == 32'd0);
                            a_d     = bus.A;
                            if (div_d) begin
                                p_d  = {32'd0, a_mag};
                                mc_d = b_mag;
                            end else begin
                                p_d  = {32'd0, b_mag};
                                mc_d = a_mag;
                            end
                        end
                        OP_MTHI: hi_d = bus.A;
                        OP_MTLO: lo_d = bus.A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                p_d   = div_q ? {div_rem, p_q[30:0], div_ge} : {mul_sum, p_q[31:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FINISH;
                    cnt_d   = 5'd0;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (!div_q) begin
                    {hi_d, lo_d} = neg_q ? prod_neg : p_q;
                end else if (bzero_q) begin
                    hi_d = a_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    lo_d = neg_q  ? -p_q[31:0]  : p_q[31:0];
                    hi_d = aneg_q ? -p_q[63:32] : p_q[63:32];
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            p_q     <= 64'd0;
            mc_q    <= 32'd0;
            a_q     <= 32'd0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            aneg_q  <= 1'b0;
            bzero_q <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            mc_q    <= mc_d;
            a_q     <= a_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            aneg_q  <= aneg_d;
            bzero_q <= bzero_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, hand sequences
// for interlock and abort, and random ops against an arithmetic model.
module tb_muldiv_unit;
    logic clk;
    logic rstn;
    int   n_pass;
    int   n_total;

    muldiv_unit_if bus ();

    muldiv_unit dut (.clk(clk), .rstn(rstn), .bus(bus.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            3'd1: begin sq = sa * sb; {hi, lo} = sq; end
            3'd2: begin up = ua * ub; {hi, lo} = up; end
            3'd3: begin
                if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
                else begin sq = sa / sb; sr = sa % sb; lo = sq[31:0]; hi = sr[31:0]; end
            end
            3'd4: begin
                if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
                else begin lo = a / b; hi = a % b; end
            end
            default: ;
        endcase
    endtask

    // Issue an iterative op starting at a negedge, check the 33-cycle Busy
    // window, the cycle-34 Done pulse and the result. inj>0 fires an MTHI
    // of 0xDEAD in that busy cycle, which must be ignored.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int inj);
        logic        bad;
        logic [31:0] hi0, lo0;
        hi0 = bus.HI;
        lo0 = bus.LO;
        bus.Start = 1'b1; bus.MDOp = op; bus.A = a; bus.B = b;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        bus.A = $urandom; bus.B = $urandom; bus.MDOp = 3'($urandom_range(0, 7));
        bad = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) bad = 1'b1;
            if (bus.HI !== hi0 || bus.LO !== lo0) bad = 1'b1;
            bus.Start = 1'b0;
            if (i == inj) begin
                bus.Start = 1'b1; bus.MDOp = 3'd5; bus.A = 32'h0000_DEAD;
            end
        end
        @(negedge clk);
        bus.Start = 1'b0;
        chk({name, " busy_window"}, {31'd0, bad}, 32'd0);
        chk({name, " done"}, {31'd0, bus.Done}, 32'd1);
        chk({name, " busy_end"}, {31'd0, bus.Busy}, 32'd0);
        chk({name, " hi"}, bus.HI, ehi);
        chk({name, " lo"}, bus.LO, elo);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b, ehi, elo;
        logic        busy_seen;
        n_pass = 0;
        n_total = 0;

        vecs.push_back('{"mult_neg3x7",  3'd1, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB});
        vecs.push_back('{"multu_max",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
        vecs.push_back('{"mult_min_sq",  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
        vecs.push_back('{"div_neg7_2",   3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vecs.push_back('{"div_7_neg2",   3'd3, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
        vecs.push_back('{"divu_100_7",   3'd4, 32'd100,      32'd7,        32'd2,         32'd14});
        vecs.push_back('{"divu_by0",     3'd4, 32'h55,       32'd0,        32'h55,        32'hFFFF_FFFF});
        vecs.push_back('{"div_by0_neg",  3'd3, 32'hFFFF_FF00, 32'd0,        32'hFFFF_FF00, 32'hFFFF_FFFF});
        vecs.push_back('{"div_ovf",      3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});

        bus.Start = 1'b0; bus.MDOp = 3'd0; bus.A = 32'd0; bus.B = 32'd0;
        rstn = 1'b0;
        #23;
        chk("rst hi", bus.HI, 32'd0);
        chk("rst lo", bus.LO, 32'd0);
        chk("rst busy", {31'd0, bus.Busy}, 32'd0);
        chk("rst done", {31'd0, bus.Done}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // MTHI / MTLO: visible next cycle, never busy.
        busy_seen = 1'b0;
        bus.Start = 1'b1; bus.MDOp = 3'd5; bus.A = 32'h1234_5678;
        @(negedge clk);
        busy_seen |= bus.Busy;
        chk("mthi hi", bus.HI, 32'h1234_5678);
        bus.MDOp = 3'd6; bus.A = 32'hCAFE_BABE;
        @(negedge clk);
        busy_seen |= bus.Busy;
        bus.MDOp = 3'd7; bus.A = 32'h0BAD_0BAD;
        chk("mtlo lo", bus.LO, 32'hCAFE_BABE);
        chk("mtlo hi_kept", bus.HI, 32'h1234_5678);
        @(negedge clk);
        bus.MDOp = 3'd0;
        @(negedge clk);
        busy_seen |= bus.Busy;
        bus.Start = 1'b0;
        chk("reserved_nop hi", bus.HI, 32'h1234_5678);
        chk("reserved_nop lo", bus.LO, 32'hCAFE_BABE);
        chk("mt no_busy", {31'd0, busy_seen}, 32'd0);

        // Directed vectors, back to back.
        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 0);

        // MTHI issued mid-divide must be dropped.
        run_op("interlock", 3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        @(negedge clk);
        chk("interlock after hi", bus.HI, 32'd2);

        // Abort a MULT at cycle 15 with async reset.
        bus.Start = 1'b1; bus.MDOp = 3'd1; bus.A = 32'd9; bus.B = 32'd9;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (15) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("abort hi", bus.HI, 32'd0);
        chk("abort lo", bus.LO, 32'd0);
        chk("abort busy", {31'd0, bus.Busy}, 32'd0);
        chk("abort done", {31'd0, bus.Done}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        run_op("post_abort multu", 3'd2, 32'd3, 32'd5, 32'd0, 32'd15, 0);

        // Random ops against the arithmetic model.
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(1, 4));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: a = 32'h8000_0000;
                default: ;
            endcase
            ref_op(op, a, b, ehi, elo);
            run_op($sformatf("rand%0d", n), op, a, b, ehi, elo, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit that owns the HI/LO register pair of the MIPS datapath. It sits beside the combinational ALU in the execute stage and serves MULT/MULTU/DIV/DIVU/MTHI/MTLO. Operations start on a one-cycle request and run over several cycles. The controller stalls dependent MFHI/MFLO while `Busy` is high.

## Interface
- No parameters; datapath width fixed at 32, iteration count fixed at 32.
- `clk`  in  1  rising-edge clock
- `rstn`  in  1  asynchronous active-low reset
- `A`  in  32  operand rs (dividend / multiplicand / MTHI-MTLO source)
- `B`  in  32  operand rt (divisor / multiplier)
- `MDOp`  in  3  op: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved
- `Start`  in  1  request strobe, sampled at rising edge
- `Busy`  out  1  iterative operation in progress
- `Done`  out  1  one-cycle pulse: HI/LO just updated by MULT/DIV
- `HI`  out  32  HI register
- `LO`  out  32  LO register

## Operation
- Reset (`rstn`=0, async): `HI`=0, `LO`=0, `Busy`=0, `Done`=0, FSM→IDLE, iteration counter=0. An operation in flight is aborted; HI/LO are not updated.
- FSM states:
  - IDLE→RUN on `Start`=1 with MDOp∈{1..4}.
  - RUN→FINISH after 32 iterations.
  - FINISH→IDLE unconditionally.
- IDLE:
  - `Start`=1 with MDOp 5 writes `HI`←A at that edge; MDOp 6 writes `LO`←A. No Busy, no Done.
  - MDOp 0 or 7 with `Start`=1: no effect.
- Start of MULT/MULTU/DIV/DIVU: A and B are latched at the start edge. Later changes on A, B or MDOp do not affect the result.
- MULT/DIV: operands converted to magnitudes, signs recorded. MULTU/DIVU: unsigned.
- Multiply: shift-add, one multiplier bit per cycle, 64-bit product. Signed result negated in FINISH if the operand signs differ. `HI`←product[63:32], `LO`←product[31:0].
- Divide: restoring shift-subtract, one quotient bit per cycle.
  - Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - `LO`←quotient, `HI`←remainder.
  - Signed overflow 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (B=0, any divide op): `LO`=0xFFFFFFFF, `HI`=A as latched. Same latency as a normal divide.
- While `Busy`=1:
  - All `Start` requests are ignored, including MTHI/MTLO.
  - `HI`/`LO` keep their old values until the FINISH edge.
- Arithmetic is modulo 2^64 internally; no exceptions or flags.

## Timing
- `Start` sampled at edge E0, ending cycle 0.
- `Busy`=1 in cycles 1..33 (RUN 32 cycles, FINISH 1 cycle).
- HI/LO written at edge E33. In cycle 34: new `HI`/`LO` visible, `Busy`=0, `Done`=1.
- `Done` is high for exactly cycle 34 and is registered.
- Back-to-back operation: a new `Start` sampled at E34 (cycle 34) is accepted. Throughput is one op per 34 cycles.
- MTHI/MTLO: result visible in the cycle after the start edge; zero stall.
- `Busy` and `Done` are registered outputs with no combinational path from inputs.
- `rstn` asserted in any cycle: outputs cleared immediately, without waiting for a clock edge.
- After `rstn` deasserts, the first `Start` is accepted at the next edge.

## Test plan
- Reset then MTHI/MTLO:
  - A=0x12345678, MDOp=5, `Start` → HI=0x12345678 next cycle, Busy never 1.
  - A=0xCAFEBABE, MDOp=6 → LO=0xCAFEBABE, HI unchanged.
- MULT signed, A=0xFFFFFFFD (−3), B=7:
  - Busy high 33 cycles.
  - Done pulses once, cycle 34.
  - HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU, A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV, A=−7 (0xFFFFFFF9), B=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- DIVU, A=100, B=7 → LO=14, HI=2.
- DIVU with B=0, A=0x55 → LO=0xFFFFFFFF, HI=0x55 after 34 cycles.
- Busy interlock: during a DIVU, pulse `Start` with MDOp=5, A=0xDEAD at cycle 10 → ignored; HI is the final remainder, not 0xDEAD.
- Abort: deassert `rstn` at cycle 15 of a MULT → HI=LO=0 and Busy=0 immediately, no Done pulse. A following MULTU 3×5 gives LO=15, HI=0.
